// File: rtl/vga_geom_pkg.sv
// Shared geometry definitions for the VGA pong datapath: coordinate widths,
// screen limits and the moving_rect update sequencer states.
package vga_geom_pkg;

    localparam int COORD_W       = 11;
    localparam int SCALC_W       = 12;
    localparam int SCREEN_WIDTH  = 639;
    localparam int SCREEN_HEIGHT = 479;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPD_X  = 2'd1,
        UPD_Y  = 2'd2,
        BOUNDS = 2'd3
    } state_t;

    // Zero-extend an unsigned coordinate into the signed working width.
    function automatic logic signed [SCALC_W-1:0] to_scalc(input logic [COORD_W-1:0] c);
        return $signed({1'b0, c});
    endfunction

endpackage

// File: rtl/rect_axis_step.sv
// One-axis position advance: applies a signed step, clamps to
// [half, limit-half], and reflects the velocity on contact.
module rect_axis_step
    import vga_geom_pkg::*;
(
    input  logic        [COORD_W-1:0] pos,
    input  logic signed [SCALC_W-1:0] vel,
    input  logic        [COORD_W-1:0] half,
    input  logic        [COORD_W-1:0] limit,
    output logic        [COORD_W-1:0] next_pos,
    output logic signed [SCALC_W-1:0] next_vel,
    output logic                      hit_lo,
    output logic                      hit_hi
);

    logic signed [SCALC_W-1:0] np;
    logic signed [SCALC_W-1:0] lo;
    logic signed [SCALC_W-1:0] hi;
    logic signed [SCALC_W-1:0] mag;

    always_comb begin
        np       = to_scalc(pos) + vel;
        lo       = to_scalc(half);
        hi       = to_scalc(limit) - to_scalc(half);
        mag      = vel[SCALC_W-1] ? -vel : vel;
        next_pos = np[COORD_W-1:0];
        next_vel = vel;
        hit_lo   = 1'b0;
        hit_hi   = 1'b0;
        // Landing exactly on a limit is legal and neither bounces nor pulses.
        if (np < lo) begin
            next_pos = half;
            next_vel = mag;
            hit_lo   = 1'b1;
        end else if (np > hi) begin
            next_pos = hi[COORD_W-1:0];
            next_vel = -mag;
            hit_hi   = 1'b1;
        end
    end

endmodule

// File: rtl/moving_rect.sv
// Frame-synchronous rectangle object (paddle or ball) with load port, edge-hit
// pulses and bounds registers. Optional MOVING_RECT_PIXEL_HIT_EN adds in_rect.
module moving_rect
    import vga_geom_pkg::*;
#(
    parameter int SIZE_X  = 3,
    parameter int SIZE_Y  = 3,
    parameter int WIDTH   = SCREEN_WIDTH,
    parameter int HEIGHT  = SCREEN_HEIGHT,
    parameter int INIT_X  = 320,
    parameter int INIT_Y  = 240,
    parameter int SPEED_X = 2,
    parameter int SPEED_Y = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               mode,
    input  logic               dir_up,
    input  logic               dir_down,
    input  logic               set_valid,
    input  logic [COORD_W-1:0] set_x,
    input  logic [COORD_W-1:0] set_y,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [COORD_W-1:0] start_w,
    output logic [COORD_W-1:0] end_w,
    output logic [COORD_W-1:0] start_h,
    output logic [COORD_W-1:0] end_h,
    output logic               hit_l,
    output logic               hit_r,
    output logic               hit_t,
    output logic               hit_b,
    output logic               busy,
    output logic               upd_done
`ifdef MOVING_RECT_PIXEL_HIT_EN
    ,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    output logic               in_rect
`endif
);

    localparam logic [COORD_W-1:0] HALF_X = COORD_W'(SIZE_X);
    localparam logic [COORD_W-1:0] HALF_Y = COORD_W'(SIZE_Y);
    localparam logic [COORD_W-1:0] LIM_X  = COORD_W'(WIDTH);
    localparam logic [COORD_W-1:0] LIM_Y  = COORD_W'(HEIGHT);
    localparam logic [COORD_W-1:0] X_MAX  = COORD_W'(WIDTH - SIZE_X);
    localparam logic [COORD_W-1:0] Y_MAX  = COORD_W'(HEIGHT - SIZE_Y);
    localparam logic [COORD_W-1:0] X_RST  = COORD_W'(INIT_X);
    localparam logic [COORD_W-1:0] Y_RST  = COORD_W'(INIT_Y);

    localparam logic signed [SCALC_W-1:0] SPD_X = SCALC_W'(SPEED_X);
    localparam logic signed [SCALC_W-1:0] SPD_Y = SCALC_W'(SPEED_Y);

    function automatic logic [COORD_W-1:0] clamp_coord(
        input logic [COORD_W-1:0] v,
        input logic [COORD_W-1:0] lo,
        input logic [COORD_W-1:0] hi
    );
        if (to_scalc(v) < to_scalc(lo)) return lo;
        if (to_scalc(v) > to_scalc(hi)) return hi;
        return v;
    endfunction

    state_t state;
    state_t next_state;

    logic                      load_go;
    logic                      tick_go;
    logic                      mode_q;
    logic                      up_q;
    logic                      down_q;
    logic signed [SCALC_W-1:0] vx;
    logic signed [SCALC_W-1:0] vy;
    logic signed [SCALC_W-1:0] vel_y;
    logic                      pend_valid;
    logic        [COORD_W-1:0] pend_x;
    logic        [COORD_W-1:0] pend_y;
    logic        [COORD_W-1:0] ld_x;
    logic        [COORD_W-1:0] ld_y;

    logic        [COORD_W-1:0] sx_pos;
    logic signed [SCALC_W-1:0] sx_vel;
    logic                      sx_lo;
    logic                      sx_hi;
    logic        [COORD_W-1:0] sy_pos;
    logic signed [SCALC_W-1:0] sy_vel;
    logic                      sy_lo;
    logic                      sy_hi;

    rect_axis_step u_step_x (
        .pos      (x),
        .vel      (vx),
        .half     (HALF_X),
        .limit    (LIM_X),
        .next_pos (sx_pos),
        .next_vel (sx_vel),
        .hit_lo   (sx_lo),
        .hit_hi   (sx_hi)
    );

    rect_axis_step u_step_y (
        .pos      (y),
        .vel      (vel_y),
        .half     (HALF_Y),
        .limit    (LIM_Y),
        .next_pos (sy_pos),
        .next_vel (sy_vel),
        .hit_lo   (sy_lo),
        .hit_hi   (sy_hi)
    );

    // Paddles use a per-frame step from the captured direction bits; only the ball keeps vy.
    always_comb begin
        vel_y = '0;
        if (mode_q)
            vel_y = vy;
        else if (up_q && !down_q)
            vel_y = -SPD_Y;
        else if (down_q && !up_q)
            vel_y = SPD_Y;
    end

    // A fresh set_valid carries the newest coordinates, so it beats a stored one.
    assign ld_x = set_valid ? set_x : pend_x;
    assign ld_y = set_valid ? set_y : pend_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        load_go    = 1'b0;
        tick_go    = 1'b0;
        case (state)
            IDLE: begin
                if (set_valid || pend_valid) begin
                    load_go    = 1'b1;
                    next_state = BOUNDS;
                end else if (frame_tick) begin
                    tick_go    = 1'b1;
                    next_state = UPD_X;
                end
            end
            UPD_X: begin
                busy       = 1'b1;
                next_state = UPD_Y;
            end
            UPD_Y: begin
                busy       = 1'b1;
                next_state = BOUNDS;
            end
            BOUNDS: begin
                busy       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x          <= X_RST;
            y          <= Y_RST;
            vx         <= SPD_X;
            vy         <= SPD_Y;
            start_w    <= X_RST - HALF_X;
            end_w      <= X_RST + HALF_X;
            start_h    <= Y_RST - HALF_Y;
            end_h      <= Y_RST + HALF_Y;
            hit_l      <= 1'b0;
            hit_r      <= 1'b0;
            hit_t      <= 1'b0;
            hit_b      <= 1'b0;
            upd_done   <= 1'b0;
            mode_q     <= 1'b0;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
            pend_valid <= 1'b0;
            pend_x     <= '0;
            pend_y     <= '0;
        end else begin
            hit_l    <= 1'b0;
            hit_r    <= 1'b0;
            hit_t    <= 1'b0;
            hit_b    <= 1'b0;
            upd_done <= 1'b0;

            if (busy && set_valid) begin
                pend_valid <= 1'b1;
                pend_x     <= set_x;
                pend_y     <= set_y;
            end

            if (load_go) begin
                x          <= clamp_coord(ld_x, HALF_X, X_MAX);
                y          <= clamp_coord(ld_y, HALF_Y, Y_MAX);
                pend_valid <= 1'b0;
            end

            if (tick_go) begin
                mode_q <= mode;
                up_q   <= dir_up;
                down_q <= dir_down;
            end

            case (state)
                UPD_X: begin
                    if (mode_q) begin
                        x     <= sx_pos;
                        vx    <= sx_vel;
                        hit_l <= sx_lo;
                        hit_r <= sx_hi;
                    end
                end
                UPD_Y: begin
                    y     <= sy_pos;
                    hit_t <= sy_lo;
                    hit_b <= sy_hi;
                    if (mode_q)
                        vy <= sy_vel;
                end
                BOUNDS: begin
                    start_w  <= x - HALF_X;
                    end_w    <= x + HALF_X;
                    start_h  <= y - HALF_Y;
                    end_h    <= y + HALF_Y;
                    upd_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef MOVING_RECT_PIXEL_HIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            in_rect <= 1'b0;
        else
            in_rect <= (pix_x >= start_w) && (pix_x <= end_w) &&
                       (pix_y >= start_h) && (pix_y <= end_h);
    end
`endif

endmodule

// File: tb/tb_moving_rect.sv
// Self-checking bench for moving_rect: directed test-plan steps followed by
// randomized frames and loads, compared against a frame-level reference model.
module tb_moving_rect;

    localparam int SX  = 3;
    localparam int SY  = 3;
    localparam int W   = 639;
    localparam int H   = 479;
    localparam int SPX = 2;
    localparam int SPY = 2;

    logic        clk;
    logic        rst_n;
    logic        frame_tick;
    logic        mode;
    logic        dir_up;
    logic        dir_down;
    logic        set_valid;
    logic [10:0] set_x;
    logic [10:0] set_y;
    logic [10:0] x;
    logic [10:0] y;
    logic [10:0] start_w;
    logic [10:0] end_w;
    logic [10:0] start_h;
    logic [10:0] end_h;
    logic        hit_l;
    logic        hit_r;
    logic        hit_t;
    logic        hit_b;
    logic        busy;
    logic        upd_done;
`ifdef MOVING_RECT_PIXEL_HIT_EN
    logic [10:0] pix_x;
    logic [10:0] pix_y;
    logic        in_rect;
`endif

    int passed = 0;
    int total  = 0;

    // Reference state: centre and ball velocity
    int mx, my, mvx, mvy;

    moving_rect dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .mode       (mode),
        .dir_up     (dir_up),
        .dir_down   (dir_down),
        .set_valid  (set_valid),
        .set_x      (set_x),
        .set_y      (set_y),
        .x          (x),
        .y          (y),
        .start_w    (start_w),
        .end_w      (end_w),
        .start_h    (start_h),
        .end_h      (end_h),
        .hit_l      (hit_l),
        .hit_r      (hit_r),
        .hit_t      (hit_t),
        .hit_b      (hit_b),
        .busy       (busy),
        .upd_done   (upd_done)
`ifdef MOVING_RECT_PIXEL_HIT_EN
        ,
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .in_rect    (in_rect)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_reset();
        mx = 320; my = 240; mvx = SPX; mvy = SPY;
    endtask

    task automatic model_load(input int sx, input int sy);
        mx = clampi(sx, SX, W - SX);
        my = clampi(sy, SY, H - SY);
    endtask

    // One frame of motion: the object moves by its step and rebounds off the walls.
    task automatic model_frame(input bit m, input bit up, input bit dn,
                               output bit el, output bit er, output bit et, output bit eb);
        int nx, ny, st;
        el = 0; er = 0; et = 0; eb = 0;
        if (m) begin
            nx = mx + mvx;
            if (nx < SX)          begin mx = SX;     mvx = SPX;  el = 1; end
            else if (nx > W - SX) begin mx = W - SX; mvx = -SPX; er = 1; end
            else mx = nx;
            st = mvy;
        end else begin
            st = (up && !dn) ? -SPY : (dn && !up) ? SPY : 0;
        end
        ny = my + st;
        if (ny < SY)          begin my = SY;     et = 1; if (m) mvy = SPY;  end
        else if (ny > H - SY) begin my = H - SY; eb = 1; if (m) mvy = -SPY; end
        else my = ny;
    endtask

    task automatic check_pos(input string tag);
        check({tag, ".x"},       x,       mx);
        check({tag, ".y"},       y,       my);
        check({tag, ".start_w"}, start_w, mx - SX);
        check({tag, ".end_w"},   end_w,   mx + SX);
        check({tag, ".start_h"}, start_h, my - SY);
        check({tag, ".end_h"},   end_h,   my + SY);
    endtask

    task automatic do_frame(input string tag, input bit m, input bit up, input bit dn);
        bit el, er, et, eb;
        model_frame(m, up, dn, el, er, et, eb);
        mode = m; dir_up = up; dir_down = dn; frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        // Inputs wiggled after acceptance must not matter.
        mode = ~m; dir_up = $urandom_range(0, 1); dir_down = $urandom_range(0, 1);
        check({tag, ".busy1"}, busy, 1);
        check({tag, ".done1"}, upd_done, 0);
        step();
        check({tag, ".hit_l"}, hit_l, el);
        check({tag, ".hit_r"}, hit_r, er);
        step();
        check({tag, ".hit_t"}, hit_t, et);
        check({tag, ".hit_b"}, hit_b, eb);
        check({tag, ".hit_lr_off"}, {hit_l, hit_r}, 0);
        check({tag, ".done3"}, upd_done, 0);
        step();
        check({tag, ".done"}, upd_done, 1);
        check({tag, ".busy_off"}, busy, 0);
        check({tag, ".hit_tb_off"}, {hit_t, hit_b}, 0);
        check_pos(tag);
    endtask

    task automatic do_load(input string tag, input int sx, input int sy);
        model_load(sx, sy);
        set_valid = 1'b1; set_x = 11'(sx); set_y = 11'(sy);
        step();
        set_valid = 1'b0;
        check({tag, ".busy"}, busy, 1);
        step();
        check({tag, ".done"}, upd_done, 1);
        check({tag, ".hits"}, {hit_l, hit_r, hit_t, hit_b}, 0);
        check_pos(tag);
    endtask

    initial begin
        bit el, er, et, eb;
        rst_n = 1'b0; frame_tick = 1'b0; mode = 1'b0; dir_up = 1'b0; dir_down = 1'b0;
        set_valid = 1'b0; set_x = '0; set_y = '0;
`ifdef MOVING_RECT_PIXEL_HIT_EN
        pix_x = '0; pix_y = '0;
`endif
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        check_pos("reset");
        check("reset.busy", busy, 0);
        check("reset.done", upd_done, 0);
        check("reset.hits", {hit_l, hit_r, hit_t, hit_b}, 0);
`ifdef MOVING_RECT_PIXEL_HIT_EN
        pix_x = 11'd320; pix_y = 11'd240;
        step();
        check("pix_inside", in_rect, 1);
        pix_x = 11'd324;
        step();
        check("pix_outside", in_rect, 0);
`endif

        // Ball hits the right wall, then travels back
        do_load("ld_right", 635, 240);
        do_frame("ball_hit_r", 1'b1, 1'b0, 1'b0);
        check("ball_hit_r.x636", x, 636);
        do_frame("ball_back", 1'b1, 1'b0, 1'b0);
        check("ball_back.x634", x, 634);

        // Paddle pinned at the top edge
        do_load("ld_top", 320, 4);
        do_frame("pad_top1", 1'b0, 1'b1, 1'b0);
        check("pad_top1.start_h0", start_h, 0);
        do_frame("pad_top2", 1'b0, 1'b1, 1'b0);
        check("pad_top2.y3", y, 3);

        // Both directions cancel
        do_frame("pad_both", 1'b0, 1'b1, 1'b1);

        // Load and tick arriving while busy
        model_frame(1'b1, 1'b0, 1'b0, el, er, et, eb);
        mode = 1'b1; frame_tick = 1'b1;
        step();
        set_valid = 1'b1; set_x = 11'd100; set_y = 11'd100;
        step();
        set_valid = 1'b0; frame_tick = 1'b0;
        step();
        step();
        check("busy_ld.frame_done", upd_done, 1);
        check("busy_ld.frame_x", x, mx);
        step();
        check("busy_ld.applying", busy, 1);
        step();
        model_load(100, 100);
        check("busy_ld.done", upd_done, 1);
        check_pos("busy_ld");
        step();
        check("busy_ld.idle", busy, 0);
        check("busy_ld.x_hold", x, 100);

        // Randomized frames and loads
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 4) == 0)
                do_load("rnd_ld", $urandom_range(0, 700), $urandom_range(0, 520));
            else
                do_frame("rnd_fr", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) step();
        end

        // Reset during UPD_Y with a load pending
        mode = 1'b1; frame_tick = 1'b1;
        step();
        frame_tick = 1'b0; set_valid = 1'b1; set_x = 11'd50; set_y = 11'd60;
        step();
        set_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_pos("mid_rst");
        check("mid_rst.busy", busy, 0);
        check("mid_rst.pulses", {hit_l, hit_r, hit_t, hit_b, upd_done}, 0);
        #1;
        rst_n = 1'b1;
        repeat (4) step();
        check_pos("post_rst");
        check("post_rst.busy", busy, 0);
        check("post_rst.done", upd_done, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/moving_rect.md
Name: moving_rect

Overview:
Registered, frame-synchronous rectangle object for the VGA pong datapath. Holds a centre position, advances it once per frame_tick (paddle mode: driven by direction inputs; ball mode: self-propelled with bounce), and publishes clamped pixel bounds for the renderer and collision logic. It replaces the purely combinational bounds calculation with a stateful object that has a load port, edge-hit events and an update handshake.

Parameters:
SIZE_X, 3, horizontal half-size in pixels
SIZE_Y, 3, vertical half-size in pixels
WIDTH, 639, last visible column
HEIGHT, 479, last visible row
INIT_X, 320, reset centre x
INIT_Y, 240, reset centre y
SPEED_X, 2, x step per frame (ball mode), 1..15
SPEED_Y, 2, y step per frame (both modes), 1..15

Ports:
clk  in  1  pixel/system clock
rst_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse per frame (vblank start)
mode  in  1  0 = paddle, 1 = ball; sampled on the accepted frame_tick
dir_up  in  1  paddle: move up this frame
dir_down  in  1  paddle: move down this frame
set_valid  in  1  load request for set_x/set_y
set_x  in  11  load centre x
set_y  in  11  load centre y
x  out  11  current centre x
y  out  11  current centre y
start_w  out  11  left bound, x-SIZE_X
end_w  out  11  right bound, x+SIZE_X
start_h  out  11  top bound, y-SIZE_Y
end_h  out  11  bottom bound, y+SIZE_Y
hit_l, hit_r, hit_t, hit_b  out  1 each  one-cycle edge-contact pulses
busy  out  1  update in progress
upd_done  out  1  one-cycle pulse, bounds valid for new position

Behaviour:
- Reset, asynchronous: x=INIT_X, y=INIT_Y, vx=+SPEED_X, vy=+SPEED_Y, bounds = INIT±SIZE, all pulses 0, busy 0, pending-load 0, state IDLE.
- Legal centre range: x in [SIZE_X, WIDTH-SIZE_X], y in [SIZE_Y, HEIGHT-SIZE_Y]. Bounds therefore never underflow or exceed WIDTH/HEIGHT. All arithmetic uses 12-bit signed intermediates.
- FSM states: IDLE -> UPD_X -> UPD_Y -> BOUNDS -> IDLE.
- IDLE:
  - A pending load is applied first: clamp set_x/set_y into range, write x/y, then go to BOUNDS. There are no hit pulses and velocity is unchanged.
  - Otherwise, if frame_tick is high, go to UPD_X and capture mode, dir_up and dir_down.
  - If set_valid and frame_tick are both high in IDLE, the load wins and the tick is dropped.
- UPD_X:
  - Ball mode: nx = x+vx. If nx < SIZE_X, x=SIZE_X, vx=+SPEED_X and pulse hit_l. If nx > WIDTH-SIZE_X, x=WIDTH-SIZE_X, vx=-SPEED_X and pulse hit_r.
  - Paddle mode: x is unchanged.
- UPD_Y:
  - Ball mode: same rule on y/vy, with hit_t/hit_b.
  - Paddle mode: step is -SPEED_Y for up-only and +SPEED_Y for down-only. Both or neither gives 0.
  - Paddle mode clamping to the range pulses hit_t/hit_b, and velocity is not stored.
- BOUNDS: register start/end from x/y. Next cycle is IDLE with upd_done=1 for one cycle. From tick acceptance, upd_done comes 4 cycles later.
- busy=1 in UPD_X, UPD_Y and BOUNDS.
- frame_tick while busy is dropped; it is not queued.
- set_valid while busy is captured into a one-entry pending register. A later set_valid overwrites it, and it is applied on the next IDLE cycle.
- Exact contact (nx == limit) does not bounce and does not pulse.
- Outputs x/y change only in UPD_*/load. Bounds change only in BOUNDS. Consumers use bounds when upd_done fires or when busy=0.
- Reset mid-update returns everything to reset values immediately and discards any pending load.

Optional Feature:
Macro MOVING_RECT_PIXEL_HIT_EN.
- Defined: adds inputs pix_x[10:0] and pix_y[10:0] and output in_rect. in_rect is registered 1 cycle after the pixel, equal to start_w<=pix_x<=end_w && start_h<=pix_y<=end_h using the current bounds registers. Reset value is 0.
- Undefined: these ports and logic are absent.

Decomposition:
- Package vga_geom_pkg holds:
  - COORD_W=11
  - screen WIDTH/HEIGHT defaults
  - state encoding constants IDLE/UPD_X/UPD_Y/BOUNDS
  - the signed intermediate width of 12
- One sub-module, rect_axis_step (combinational): given position, velocity, half-size and limit, returns next position, next velocity, and the lo/hi hit flags. It is instantiated twice, once for x and once for y.

Test Plan:
- Reset release, no ticks -> x=320, y=240, start_w=317, end_w=323, start_h=237, end_h=243, busy=0.
- Ball mode, load (635,240), one tick -> nx=637>636: x=636, hit_r pulse, vx=-2. Next tick -> x=634 with no hit.
- Paddle mode, load y=4, dir_up held, tick -> y=3, hit_t pulse, start_h=0. Second tick -> y=3 with hit_t pulse again.
- Paddle mode, dir_up=dir_down=1, tick -> y unchanged, no hits, upd_done 4 cycles after tick.
- set_valid (100,100) during busy -> update completes, then load applies. Final x=100, bounds 97..103. A tick arriving while busy changes nothing.
- Assert rst_n low in UPD_Y -> all outputs return to reset values and the pending load is lost. With MOVING_RECT_PIXEL_HIT_EN: pixel (320,240) -> in_rect=1 next cycle, (324,240) -> 0.
